phy_tx_serial: RTL and testbench
================================

Name: phy_tx_serial

Overview:
Transmit end of the PHY 2-bit serial link: serializes 9-bit words (bit 8 = valid, bits 7:0 = byte) onto a 2-bit lane at the clk16f rate, one byte every 4 clocks.
- After reset it sends a burst of COM characters so the receive side can align.
- It then sends data bytes, or IDLE characters when no valid word is offered.
- It sits between the byte-rate data path and the serial lane that feeds phy_rx.

Parameters:
COM_COUNT, 4, number of COM bytes sent after reset before data is accepted (1..15).
COM, 8'hBC, alignment character.
IDLE, 8'h7C, filler byte sent when data_in[8]=0 in DATA state.

Ports:
clk16f  input  1  serial-rate clock; all logic on posedge.
reset_L  input  1  reset, asynchronous, active-low.
data_in  input  9  bit 8 = valid, bits 7:0 = payload byte; must be held until data_ack.
data_ack  output  1  one-cycle pulse: data_in was captured.
serial  output  2  serial lane, registered, MSB pair first.
sync_done  output  1  high while in DATA state.

Behaviour:
- One clock (clk16f); reset_L asynchronous, active-low.
- Reset values (immediate on reset_L=0, including mid-byte):
  - serial=2'b00, data_ack=0, sync_done=0.
  - pair counter cnt=0, COM counter=0, state=SYNC, hold register=0.
- Pair counter cnt (2 bits) increments every clock and wraps 3->0.
- Byte boundary is the edge where cnt==0.
- At a boundary edge, select byte B:
  - SYNC: B=COM.
  - DATA with data_in[8]=1: B=data_in[7:0]; data_ack<=1 on that edge.
  - DATA with data_in[8]=0: B=IDLE; no ack.
- Byte output at the boundary edge: serial<=B[7:6] and hold<=B[5:0].
- Following edges: cnt=1 -> serial<=hold[5:4]; cnt=2 -> hold[3:2]; cnt=3 -> hold[1:0].
- data_ack deasserts on the next edge; it is never high on two consecutive cycles.
- Latency: payload sampled at boundary edge E; its pairs are visible after E, E+1, E+2, E+3. Output is gapless, one byte per 4 clocks.
- data_in is ignored at non-boundary edges. A valid word raised mid-byte waits for the next boundary.
- Stream timing after reset: the first posedge after reset_L rises is a boundary edge carrying COM pair 10.
- State machine:
  - SYNC: sends COM exactly COM_COUNT times; the COM counter increments at each boundary.
  - SYNC->DATA: on the edge where cnt==3 of the last COM. sync_done<=1 on that same edge.
  - DATA: the first DATA byte follows with no gap.
  - DATA has no exit except reset.
- Simultaneous events: reset asserted on a boundary edge wins; no ack, no byte loaded.
- data_in values with bit 8=0 never produce data_ack, regardless of bits 7:0.

Test Plan:
1. Reset low 2 cycles, then release with data_in=9'h000 -> serial 10,11,11,00 repeated 4 times (16 clocks), data_ack stays 0, sync_done rises at the 16th edge; then IDLE 01,11,11,00 repeats.
2. After sync, hold data_in=9'h1FF -> data_ack pulses once per boundary, serial 11,11,11,11 per byte; switch to 9'h188 at an ack -> 10,00,10,00.
3. Back-to-back 9'h188 then 9'h166 (each changed on its ack) -> serial 10,00,10,00,01,10,01,10 contiguous, exactly 2 acks 4 clocks apart.
4. Raise data_in=9'h1A5 at cnt==1 of an IDLE byte -> IDLE completes; the next byte is 10,10,01,01, with the ack at that boundary only.
5. Assert reset_L=0 mid-data at cnt==2 -> serial=00 and sync_done=0 immediately with no clock; after release the 4-COM burst restarts from pair 10.
6. COM_COUNT=1 build -> a single COM (10,11,11,00), then DATA; sync_done high after the 4th edge.

Source files
------------

// File: rtl/phy_tx_serial.sv
// Transmit end of the 2-bit serial PHY lane: COM alignment burst after reset,
// then one data or IDLE byte every four clk16f cycles, MSB pair first.
module phy_tx_serial #(
    parameter int          COM_COUNT = 4,
    parameter logic [7:0]  COM       = 8'hBC,
    parameter logic [7:0]  IDLE      = 8'h7C
) (
    input  logic       clk16f,
    input  logic       reset_L,
    input  logic [8:0] data_in,
    output logic       data_ack,
    output logic [1:0] serial,
    output logic       sync_done
);

    typedef enum logic [0:0] {
        SYNC = 1'b0,
        DATA = 1'b1
    } state_t;

    localparam logic [3:0] COM_LAST = 4'(COM_COUNT);

    state_t     state_r;
    logic [1:0] cnt_r;
    logic [3:0] com_cnt_r;
    logic [5:0] hold_r;
    logic [7:0] byte_s;
    logic       ack_s;

    // Byte selected for the next boundary edge and whether it consumes data_in.
    always_comb begin
        byte_s = IDLE;
        ack_s  = 1'b0;
        case (state_r)
            SYNC: begin
                byte_s = COM;
                ack_s  = 1'b0;
            end
            DATA: begin
                if (data_in[8]) begin
                    byte_s = data_in[7:0];
                    ack_s  = 1'b1;
                end else begin
                    byte_s = IDLE;
                    ack_s  = 1'b0;
                end
            end
            default: begin
                byte_s = COM;
                ack_s  = 1'b0;
            end
        endcase
    end

    // Pair serializer, COM burst counter and SYNC->DATA sequencing.
    always_ff @(posedge clk16f or negedge reset_L) begin
        if (!reset_L) begin
            state_r   <= SYNC;
            cnt_r     <= 2'd0;
            com_cnt_r <= 4'd0;
            hold_r    <= 6'd0;
            serial    <= 2'b00;
            data_ack  <= 1'b0;
            sync_done <= 1'b0;
        end else begin
            cnt_r    <= cnt_r + 2'd1;
            data_ack <= 1'b0;
            case (cnt_r)
                2'd0: begin
                    serial   <= byte_s[7:6];
                    hold_r   <= byte_s[5:0];
                    data_ack <= ack_s;
                    if (state_r == SYNC) begin
                        com_cnt_r <= com_cnt_r + 4'd1;
                    end
                end
                2'd1: serial <= hold_r[5:4];
                2'd2: serial <= hold_r[3:2];
                2'd3: begin
                    serial <= hold_r[1:0];
                    // Leave SYNC on the last pair of the final COM so DATA starts gapless.
                    if (state_r == SYNC && com_cnt_r == COM_LAST) begin
                        state_r   <= DATA;
                        sync_done <= 1'b1;
                    end
                end
                default: serial <= 2'b00;
            endcase
        end
    end

endmodule

// File: tb/tb_phy_tx_serial.sv
// Self-checking bench for phy_tx_serial: an edge-count stream model checked on
// every falling edge, plus directed scenarios with literal pair sequences.
module tb_phy_tx_serial;

    localparam int         TB_COM_COUNT = 4;
    localparam logic [7:0] TB_COM       = 8'hBC;
    localparam logic [7:0] TB_IDLE      = 8'h7C;

    logic       clk16f;
    logic       reset_L;
    logic [8:0] data_in;
    logic       data_ack;
    logic [1:0] serial;
    logic       sync_done;

    logic       reset_L1;
    logic [8:0] data_in1;
    logic       data_ack1;
    logic [1:0] serial1;
    logic       sync_done1;

    int n_checks = 0;
    int n_fail   = 0;
    bit run      = 1'b0;

    phy_tx_serial #(.COM_COUNT(TB_COM_COUNT), .COM(TB_COM), .IDLE(TB_IDLE)) dut (
        .clk16f(clk16f), .reset_L(reset_L), .data_in(data_in),
        .data_ack(data_ack), .serial(serial), .sync_done(sync_done)
    );

    phy_tx_serial #(.COM_COUNT(1)) dut1 (
        .clk16f(clk16f), .reset_L(reset_L1), .data_in(data_in1),
        .data_ack(data_ack1), .serial(serial1), .sync_done(sync_done1)
    );

    initial begin
        clk16f = 1'b0;
        forever #5 clk16f = ~clk16f;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Stream model: edge k after reset lies in byte k/4 at pair k%4.
    int         k;
    logic [7:0] cur_byte;
    logic [1:0] exp_serial;
    logic       exp_ack;
    logic       exp_sync;

    always @(posedge clk16f or negedge reset_L) begin
        if (!reset_L) begin
            k          = 0;
            cur_byte   = 8'h00;
            exp_serial = 2'b00;
            exp_ack    = 1'b0;
            exp_sync   = 1'b0;
        end else begin
            exp_ack = 1'b0;
            if (k % 4 == 0) begin
                if (k / 4 < TB_COM_COUNT) begin
                    cur_byte = TB_COM;
                end else if (data_in[8]) begin
                    cur_byte = data_in[7:0];
                    exp_ack  = 1'b1;
                end else begin
                    cur_byte = TB_IDLE;
                end
            end
            exp_serial = 2'((cur_byte >> (6 - 2 * (k % 4))) & 8'h03);
            exp_sync   = (k >= 4 * TB_COM_COUNT - 1);
            k++;
        end
    end

    always @(negedge clk16f) begin
        if (run) begin
            chk("model_serial", 32'(serial), 32'(exp_serial));
            chk("model_ack", 32'(data_ack), 32'(exp_ack));
            chk("model_sync", 32'(sync_done), 32'(exp_sync));
        end
    end

    logic [1:0] tab_com  [4] = '{2'b10, 2'b11, 2'b11, 2'b00};
    logic [1:0] tab_idle [4] = '{2'b01, 2'b11, 2'b11, 2'b00};
    logic [1:0] tab_88   [4] = '{2'b10, 2'b00, 2'b10, 2'b00};
    logic [1:0] tab_66   [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [1:0] tab_a5   [4] = '{2'b10, 2'b10, 2'b01, 2'b01};

    int acks;

    initial begin
        reset_L  = 1'b0;
        reset_L1 = 1'b0;
        data_in  = 9'h000;
        data_in1 = 9'h000;
        @(negedge clk16f);
        run = 1'b1;
        @(negedge clk16f);
        chk("reset_serial", 32'(serial), 32'd0);
        chk("reset_ack", 32'(data_ack), 32'd0);
        chk("reset_sync", 32'(sync_done), 32'd0);
        chk("reset1_serial", 32'(serial1), 32'd0);

        // COM burst then IDLE, on both the 4-COM and 1-COM builds.
        reset_L  = 1'b1;
        reset_L1 = 1'b1;
        acks = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk16f);
            chk("sync_serial", 32'(serial), 32'(i < 16 ? tab_com[i % 4] : tab_idle[i % 4]));
            chk("sync_flag", 32'(sync_done), 32'(i >= 15));
            chk("com1_serial", 32'(serial1), 32'(i < 4 ? tab_com[i % 4] : tab_idle[i % 4]));
            chk("com1_sync", 32'(sync_done1), 32'(i >= 3));
            if (data_ack) acks++;
        end
        chk("sync_no_ack", 32'(acks), 32'd0);

        // 1FF held for two bytes, then 188 and 166 back to back.
        data_in = 9'h1FF;
        acks = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk16f);
            if (i < 8)
                chk("ff_serial", 32'(serial), 32'(2'b11));
            else if (i < 12)
                chk("b88_serial", 32'(serial), 32'(tab_88[i % 4]));
            else
                chk("b66_serial", 32'(serial), 32'(tab_66[i % 4]));
            chk("data_ack", 32'(data_ack), 32'(i % 4 == 0));
            if (data_ack && i >= 8) acks++;
            if (i == 4) data_in = 9'h188;
            if (i == 8) data_in = 9'h166;
            if (i == 12) data_in = 9'h000;
        end
        chk("b2b_acks", 32'(acks), 32'd2);

        // Valid word raised mid-IDLE waits for the next boundary.
        acks = 0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk16f);
            chk("mid_serial", 32'(serial), 32'(j < 4 ? tab_idle[j] : tab_a5[j - 4]));
            chk("mid_ack", 32'(data_ack), 32'(j == 4));
            if (data_ack) acks++;
            if (j == 0) data_in = 9'h1A5;
            if (j == 4) data_in = 9'h000;
        end
        chk("mid_acks", 32'(acks), 32'd1);

        // Asynchronous reset in the middle of a data byte.
        data_in = 9'h1FF;
        @(negedge clk16f);
        @(negedge clk16f);
        chk("pre_rst_serial", 32'(serial), 32'(2'b11));
        #2 reset_L = 1'b0;
        #1;
        chk("async_serial", 32'(serial), 32'd0);
        chk("async_sync", 32'(sync_done), 32'd0);
        chk("async_ack", 32'(data_ack), 32'd0);
        @(negedge clk16f);
        @(negedge clk16f);
        data_in = 9'h000;
        reset_L = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk16f);
            chk("resync_serial", 32'(serial), 32'(i < 16 ? tab_com[i % 4] : tab_idle[i % 4]));
            chk("resync_flag", 32'(sync_done), 32'(i >= 15));
        end

        run = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
